// File: rtl/legv8_isa_pkg.sv
// Shared LEGv8 ISA definitions: op-select codes, opcode fields and immediate widths.
// The control decoder imports the same constants, so encode and decode cannot diverge.
package legv8_isa_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOrr  = 4'd3,
        OpAddi = 4'd4,
        OpSubi = 4'd5,
        OpAndi = 4'd6,
        OpOrri = 4'd7,
        OpLdur = 4'd8,
        OpStur = 4'd9,
        OpB    = 4'd10,
        OpCbz  = 4'd11
    } op_e;

    localparam logic [10:0] OpcAdd  = 11'b10001011000;
    localparam logic [10:0] OpcSub  = 11'b11001011000;
    localparam logic [10:0] OpcAnd  = 11'b10001010000;
    localparam logic [10:0] OpcOrr  = 11'b10101010000;
    localparam logic [9:0]  OpcAddi = 10'b1001000100;
    localparam logic [9:0]  OpcSubi = 10'b1101000100;
    localparam logic [9:0]  OpcAndi = 10'b1001001000;
    localparam logic [9:0]  OpcOrri = 10'b1011001000;
    localparam logic [10:0] OpcLdur = 11'b11111000010;
    localparam logic [10:0] OpcStur = 11'b11111000000;
    localparam logic [5:0]  OpcB    = 6'b000101;
    localparam logic [7:0]  OpcCbz  = 8'b10110100;

    localparam int unsigned ImmIWidth  = 12;
    localparam int unsigned ImmDWidth  = 9;
    localparam int unsigned ImmBWidth  = 26;
    localparam int unsigned ImmCbWidth = 19;

    // True when imm survives truncation to width bits and sign-extension back.
    function automatic logic fits_signed(logic [31:0] imm, int unsigned width);
        logic signed [31:0] hi;
        hi = $signed(imm) >>> (width - 1);
        return (hi == '0) || (hi == '1);
    endfunction

    function automatic logic fits_unsigned(logic [31:0] imm, int unsigned width);
        return (imm >> width) == '0;
    endfunction

endpackage

// File: rtl/legv8_field_pack.sv
// Combinational packer: symbolic instruction fields to a 32-bit LEGv8 word,
// flagging illegal op selects and immediates that do not fit their field.
module legv8_field_pack
    import legv8_isa_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rn,
    input  logic [4:0]  i_rm,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal,
    output logic        o_range_err
);

    logic w_fit_i, w_fit_d, w_fit_b, w_fit_cb;

    assign w_fit_i  = fits_unsigned(i_imm, ImmIWidth);
    assign w_fit_d  = fits_signed(i_imm, ImmDWidth);
    assign w_fit_b  = fits_signed(i_imm, ImmBWidth);
    assign w_fit_cb = fits_signed(i_imm, ImmCbWidth);

    // Out-of-range immediates are still packed, truncated to the field width.
    always_comb begin
        o_word      = '0;
        o_illegal   = 1'b0;
        o_range_err = 1'b0;
        case (i_op)
            OpAdd:  o_word = {OpcAdd, i_rm, 6'd0, i_rn, i_rd};
            OpSub:  o_word = {OpcSub, i_rm, 6'd0, i_rn, i_rd};
            OpAnd:  o_word = {OpcAnd, i_rm, 6'd0, i_rn, i_rd};
            OpOrr:  o_word = {OpcOrr, i_rm, 6'd0, i_rn, i_rd};
            OpAddi: begin o_word = {OpcAddi, i_imm[11:0], i_rn, i_rd}; o_range_err = !w_fit_i; end
            OpSubi: begin o_word = {OpcSubi, i_imm[11:0], i_rn, i_rd}; o_range_err = !w_fit_i; end
            OpAndi: begin o_word = {OpcAndi, i_imm[11:0], i_rn, i_rd}; o_range_err = !w_fit_i; end
            OpOrri: begin o_word = {OpcOrri, i_imm[11:0], i_rn, i_rd}; o_range_err = !w_fit_i; end
            OpLdur: begin
                o_word      = {OpcLdur, i_imm[8:0], 2'b00, i_rn, i_rd};
                o_range_err = !w_fit_d;
            end
            OpStur: begin
                o_word      = {OpcStur, i_imm[8:0], 2'b00, i_rn, i_rd};
                o_range_err = !w_fit_d;
            end
            OpB: begin
                o_word      = {OpcB, i_imm[25:0]};
                o_range_err = !w_fit_b;
            end
            OpCbz: begin
                o_word      = {OpcCbz, i_imm[18:0], i_rd};
                o_range_err = !w_fit_cb;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Streaming instruction encoder: accepts symbolic instructions over valid/ready and
// writes packed LEGv8 words sequentially into instruction memory.
module legv8_instr_encoder
    import legv8_isa_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [31:0]       in_imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal,
    output logic              err_range
);

    logic [ADDR_W:0]   r_count;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_err_illegal;
    logic              r_err_range;

    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_range_err;
    logic        w_full;
    logic        w_accept;
    logic        w_write;

    legv8_field_pack u_field_pack (
        .i_op        (in_op),
        .i_rd        (in_rd),
        .i_rn        (in_rn),
        .i_rm        (in_rm),
        .i_imm       (in_imm),
        .o_word      (w_word),
        .o_illegal   (w_illegal),
        .o_range_err (w_range_err)
    );

    assign w_full   = (r_count == (ADDR_W + 1)'(DEPTH));
    assign in_ready = !w_full && !clear;
    assign w_accept = in_valid && in_ready;
    assign w_write  = w_accept && !w_illegal;

    // The counter saturates at DEPTH via in_ready; it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count       <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_err_illegal <= 1'b0;
            r_err_range   <= 1'b0;
        end else if (clear) begin
            r_count       <= '0;
            r_wr_en       <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_range   <= 1'b0;
        end else begin
            r_wr_en       <= w_write;
            r_err_illegal <= w_accept && w_illegal;
            r_err_range   <= w_write && w_range_err;
            if (w_write) begin
                r_wr_addr <= r_count[ADDR_W-1:0];
                r_wr_data <= w_word;
                r_count   <= r_count + 1'b1;
            end
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign count       = r_count;
    assign full        = w_full;
    assign err_illegal = r_err_illegal;
    assign err_range   = r_err_range;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Scoreboard bench for legv8_instr_encoder: driver pushes expected writes/errors from an
// arithmetic reference model; a negedge monitor pops and compares what the DUT presents.
module tb_legv8_instr_encoder;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [31:0]       in_imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err_illegal;
    logic              err_range;

    legv8_instr_encoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rn       (in_rn),
        .in_rm       (in_rm),
        .in_imm      (in_imm),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .count       (count),
        .full        (full),
        .err_illegal (err_illegal),
        .err_range   (err_range)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              illg;
        bit [ADDR_W-1:0] addr;
        bit [31:0]       data;
        bit              rng;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_cnt = 0;

    task automatic chk(input string name, input longint got, input longint want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: builds each word from field values by plain arithmetic.
    function automatic void model(input int op, input int rd, input int rn, input int rm,
                                  input logic [31:0] imm, output bit illg,
                                  output bit [31:0] word, output bit rng);
        longint s;
        longint acc;
        s     = longint'($signed(imm));
        acc   = 0;
        illg  = 1'b0;
        rng   = 1'b0;
        case (op)
            0: acc = 1112 * 2**21 + rm * 65536 + rn * 32 + rd;
            1: acc = 1624 * 2**21 + rm * 65536 + rn * 32 + rd;
            2: acc = 1104 * 2**21 + rm * 65536 + rn * 32 + rd;
            3: acc = 1360 * 2**21 + rm * 65536 + rn * 32 + rd;
            4, 5, 6, 7: begin
                case (op)
                    4: acc = 580;
                    5: acc = 836;
                    6: acc = 584;
                    default: acc = 712;
                endcase
                acc = acc * 2**22 + (s & 4095) * 1024 + rn * 32 + rd;
                rng = !(s >= 0 && s <= 4095);
            end
            8, 9: begin
                acc = ((op == 8) ? 1986 : 1984) * 2**21 + (s & 511) * 4096 + rn * 32 + rd;
                rng = !(s >= -256 && s <= 255);
            end
            10: begin
                acc = 5 * 2**26 + (s & (2**26 - 1));
                rng = !(s >= -(2**25) && s < 2**25);
            end
            11: begin
                acc = 180 * 2**24 + (s & (2**19 - 1)) * 32 + rd;
                rng = !(s >= -(2**18) && s < 2**18);
            end
            default: illg = 1'b1;
        endcase
        word = acc[31:0];
    endfunction

    // Monitor: every cycle, the front entry (if any) is what the DUT must present now.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wr_en", wr_en, !e.illg);
            chk("err_illegal", err_illegal, e.illg);
            chk("err_range", err_range, e.rng);
            if (!e.illg) begin
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
            end
        end else begin
            chk("idle_wr_en", wr_en, 0);
            chk("idle_err_illegal", err_illegal, 0);
            chk("idle_err_range", err_range, 0);
        end
        chk("count", count, m_cnt);
        chk("full", full, m_cnt == DEPTH);
    end

    task automatic tick(input bit v, input bit clr, input bit ovr = 1'b0,
                        input bit [31:0] ow = '0, input bit orng = 1'b0);
        exp_t e;
        bit   illg;
        bit   rng;
        bit [31:0] w;
        in_valid = v;
        clear    = clr;
        @(negedge clk);
        chk("in_ready", in_ready, (m_cnt < DEPTH) && !clr);
        @(posedge clk);
        if (clr) begin
            m_cnt = 0;
        end else if (v && m_cnt < DEPTH) begin
            model(int'(in_op), int'(in_rd), int'(in_rn), int'(in_rm), in_imm, illg, w, rng);
            if (ovr) begin
                w   = ow;
                rng = orng;
            end
            e.illg = illg;
            e.addr = m_cnt[ADDR_W-1:0];
            e.data = w;
            e.rng  = illg ? 1'b0 : rng;
            sb.push_back(e);
            if (!illg) m_cnt++;
        end
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic issue(input int op, input int rd, input int rn, input int rm,
                         input logic [31:0] imm, input bit ovr = 1'b0,
                         input bit [31:0] ow = '0, input bit orng = 1'b0);
        in_op  = op[3:0];
        in_rd  = rd[4:0];
        in_rn  = rn[4:0];
        in_rm  = rm[4:0];
        in_imm = imm;
        tick(1'b1, 1'b0, ovr, ow, orng);
    endtask

    function automatic logic [31:0] gen_imm();
        int pick[10];
        pick = '{4095, 4096, 255, 256, -256, -257, 2**25 - 1, 2**25, -(2**18), -(2**18) - 1};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return $urandom_range(0, 4095);
            2: return 32'($urandom_range(0, 511)) - 32'd256;
            default: return pick[$urandom_range(0, 9)];
        endcase
    endfunction

    task automatic rand_issue(input int max_op);
        issue($urandom_range(0, max_op), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), gen_imm());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_rd    = '0;
        in_rn    = '0;
        in_rm    = '0;
        in_imm   = '0;
        @(negedge clk);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed vectors with independently stated expected words.
        issue(0, 1, 2, 3, 32'd0, 1'b1, 32'h8B030041, 1'b0);
        issue(4, 1, 2, 0, 32'd5, 1'b1, 32'h91001441, 1'b0);
        issue(8, 3, 4, 0, 32'd8, 1'b1, 32'hF8408083, 1'b0);
        issue(10, 0, 0, 0, 32'hFFFF_FFFF, 1'b1, 32'h17FFFFFF, 1'b0);
        issue(11, 5, 0, 0, 32'd2, 1'b1, 32'hB4000045, 1'b0);
        issue(4, 1, 2, 0, 32'd4096, 1'b1, 32'h91000041, 1'b1);
        issue(13, 1, 2, 3, 32'd0);
        tick(1'b0, 1'b0);

        // Random mix including illegal ops and idle cycles; ends on a write then clear.
        tick(1'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 4) == 0) tick(1'b0, 1'b0);
            else rand_issue(15);
        end
        rand_issue(11);
        tick(1'b0, 1'b1);

        // Fill to DEPTH with in_valid held; three extra attempts must be refused.
        for (int i = 0; i < int'(DEPTH) + 3; i++) rand_issue(11);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        issue(0, 7, 8, 9, 32'd0);
        tick(1'b0, 1'b0);

        // Asynchronous reset while a write is on the bus.
        issue(1, 4, 5, 6, 32'd0);
        reset = 1'b1;
        sb.delete();
        m_cnt = 0;
        #1;
        chk("arst_wr_en", wr_en, 0);
        chk("arst_count", count, 0);
        chk("arst_full", full, 0);
        chk("arst_wr_data", wr_data, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        issue(2, 9, 10, 11, 32'd0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
